// File: rtl/booth_pkg.sv
// Shared sizing and state encoding for the Booth radix-4 partial-product accumulator.
package booth_pkg;

    localparam int unsigned PP_NUM = 33;
    localparam int unsigned PP_W   = 66;
    localparam int unsigned PROD_W = 128;
    localparam int unsigned K_W    = 6;

    localparam logic [K_W-1:0] K_LAST = K_W'(PP_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/booth_pp_shift_add.sv
// One accumulation step: sign-extend pp to the product width, weight it by 4^k, add.
module booth_pp_shift_add
    import booth_pkg::*;
(
    input  logic [PROD_W-1:0] acc,
    input  logic [PP_W-1:0]   pp,
    input  logic [K_W-1:0]    k,
    output logic [PROD_W-1:0] acc_next
);

    logic [PROD_W-1:0] pp_ext;
    logic [PROD_W-1:0] pp_shifted;

    assign pp_ext     = {{(PROD_W - PP_W){pp[PP_W-1]}}, pp};
    // Digit k carries weight 4^k; bits pushed past the top are dropped by the fixed width.
    assign pp_shifted = pp_ext << {k, 1'b0};
    assign acc_next   = acc + pp_shifted;

endmodule

// File: rtl/booth_pp_accum.sv
// Sequentially sums 33 Booth radix-4 partial products, one per clock, into a 128-bit product.
module booth_pp_accum
    import booth_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [PP_NUM*PP_W-1:0]   i_pp,
    input  logic                     i_clear,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [PROD_W-1:0]        o_product,
    output logic                     o_busy
);

    state_t                        state;
    logic [K_W-1:0]                k;
    logic [PROD_W-1:0]             acc;
    logic [PROD_W-1:0]             acc_next;
    logic [PP_NUM-1:0][PP_W-1:0]   pp_q;
    logic [PP_W-1:0]               pp_sel;

    assign pp_sel = pp_q[k];

    booth_pp_shift_add u_shift_add (
        .acc      (acc),
        .pp       (pp_sel),
        .k        (k),
        .acc_next (acc_next)
    );

    assign o_in_ready = (state == IDLE) && !i_clear;
    assign o_busy     = (state != IDLE);
    assign o_product  = acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            k           <= '0;
            acc         <= '0;
            pp_q        <= '0;
            o_out_valid <= 1'b0;
        end else if (i_clear) begin
            // Abort wins over any handshake offered in the same cycle.
            state       <= IDLE;
            k           <= '0;
            acc         <= '0;
            o_out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_in_valid) begin
                        pp_q  <= i_pp;
                        acc   <= '0;
                        k     <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    k   <= k + K_W'(1);
                    if (k == K_LAST) begin
                        state       <= DONE;
                        o_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        state       <= IDLE;
                        o_out_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Randomized self-checking bench: Booth digits generated here, results checked against a*b.
module tb_booth_pp_accum;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_in_valid;
    logic          o_in_ready;
    logic [2177:0] i_pp;
    logic          i_clear;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [127:0]  o_product;
    logic          o_busy;

    int checks = 0;
    int errors = 0;

    booth_pp_accum dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_pp        (i_pp),
        .i_clear     (i_clear),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_product   (o_product),
        .o_busy      (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Radix-4 Booth recoding of b (multiplier) applied to a (multiplicand), 66-bit digits.
    function automatic logic [2177:0] booth_gen(input logic [63:0] a, input logic [63:0] b,
                                                input bit sa, input bit sb);
        logic [65:0]   ea;
        logic [65:0]   eb;
        logic [66:0]   bx;
        logic [2:0]    trip;
        logic [65:0]   m;
        logic [2177:0] v;
        ea = sa ? {{2{a[63]}}, a} : {2'b00, a};
        eb = sb ? {{2{b[63]}}, b} : {2'b00, b};
        bx = {eb, 1'b0};
        v  = '0;
        for (int k = 0; k < 33; k++) begin
            trip = bx[2*k+2 -: 3];
            case (trip)
                3'b001, 3'b010: m = ea;
                3'b011:         m = ea << 1;
                3'b100:         m = -(ea << 1);
                3'b101, 3'b110: m = -ea;
                default:        m = '0;
            endcase
            v[66*k +: 66] = m;
        end
        return v;
    endfunction

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input bit sa, input bit sb);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [2177:0] rand_pp();
        logic [2177:0] v;
        for (int k = 0; k < 33; k++)
            v[66*k +: 66] = {2'($urandom), $urandom, $urandom};
        return v;
    endfunction

    task automatic start_op(input logic [2177:0] pp);
        i_pp       = pp;
        i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
        i_pp       = rand_pp();
    endtask

    // Waits for o_out_valid while scribbling on the input side; lat counts edges after acceptance.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!o_out_valid && lat < 60) begin
            i_in_valid = 1'($urandom_range(0, 1));
            i_pp       = rand_pp();
            tick();
            lat++;
        end
        i_in_valid = 1'b0;
    endtask

    task automatic release_out();
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_clear     = 1'b0;
        i_out_ready = 1'b0;
        i_pp        = rand_pp();
        #12;
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_out_valid); end
        checks++; if (o_product !== 128'd0) begin errors++; $display("FAIL reset_product got %h want 0", o_product); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", o_in_ready); end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_known();
        logic [63:0]  ta [4];
        logic [63:0]  tb [4];
        bit           tsa [4];
        bit           tsb [4];
        logic [127:0] texp [4];
        int           lat;
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'hFFFF_FFFF_FFFF_FFFF; tsa[0] = 0; tsb[0] = 0;
        texp[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        ta[1] = 64'h8000_0000_0000_0000; tb[1] = 64'h8000_0000_0000_0000; tsa[1] = 1; tsb[1] = 1;
        texp[1] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
        ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb[2] = 64'hFFFF_FFFF_FFFF_FFFF; tsa[2] = 1; tsb[2] = 1;
        texp[2] = 128'd1;
        ta[3] = 64'hFFFF_FFFF_FFFF_FFFF; tb[3] = 64'hFFFF_FFFF_FFFF_FFFF; tsa[3] = 1; tsb[3] = 0;
        texp[3] = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001;
        for (int i = 0; i < 4; i++) begin
            start_op(booth_gen(ta[i], tb[i], tsa[i], tsb[i]));
            wait_done(lat);
            checks++; if (lat != 33) begin errors++; $display("FAIL known%0d_latency got %0d want 33", i, lat); end
            checks++; if (o_product !== texp[i]) begin errors++; $display("FAIL known%0d_product got %h want %h", i, o_product, texp[i]); end
            release_out();
            checks++; if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL known%0d_release got valid=%0b busy=%0b want 0 0", i, o_out_valid, o_busy); end
        end
    endtask

    task automatic test_random();
        logic [63:0]  a;
        logic [63:0]  b;
        bit           sa;
        bit           sb;
        logic [127:0] exp;
        int           lat;
        for (int i = 0; i < 20; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            exp = ref_mul(a, b, sa, sb);
            start_op(booth_gen(a, b, sa, sb));
            wait_done(lat);
            checks++; if (lat != 33) begin errors++; $display("FAIL rand%0d_latency got %0d want 33", i, lat); end
            checks++; if (o_product !== exp) begin errors++; $display("FAIL rand%0d_product a=%h b=%h s=%0b%0b got %h want %h", i, a, b, sa, sb, o_product, exp); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
        int           lat;
        int           bad;
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        exp = ref_mul(a, b, 1'b1, 1'b0);
        start_op(booth_gen(a, b, 1'b1, 1'b0));
        wait_done(lat);
        checks++; if (o_product !== exp) begin errors++; $display("FAIL bp_product got %h want %h", o_product, exp); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            i_in_valid = 1'b1;
            i_pp       = rand_pp();
            tick();
            if (o_out_valid !== 1'b1 || o_product !== exp || o_in_ready !== 1'b0) bad++;
        end
        i_in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        release_out();
        checks++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_accept got busy=%0b valid=%0b want 0 0", o_busy, o_out_valid); end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        start_op(booth_gen({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0));
        for (int i = 0; i < 17; i++) tick();
        i_clear    = 1'b1;
        i_in_valid = 1'b1;
        i_pp       = rand_pp();
        #1;
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %0b want 0", o_in_ready); end
        tick();
        i_clear    = 1'b0;
        i_in_valid = 1'b0;
        checks++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_product !== 128'd0)
            begin errors++; $display("FAIL abort_idle got busy=%0b valid=%0b prod=%h want 0 0 0", o_busy, o_out_valid, o_product); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_out_valid || o_busy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_valid got %0d active cycles want 0", seen); end
        start_op(booth_gen(64'd3, 64'd5, 1'b0, 1'b0));
        wait_done(lat);
        checks++; if (o_product !== 128'd15 || lat != 33) begin errors++; $display("FAIL abort_next got %h lat %0d want 15 lat 33", o_product, lat); end
        // Clear in DONE while the consumer is ready: accumulator must be zeroed too.
        i_clear     = 1'b1;
        i_out_ready = 1'b1;
        tick();
        i_clear     = 1'b0;
        i_out_ready = 1'b0;
        checks++; if (o_out_valid !== 1'b0 || o_product !== 128'd0 || o_busy !== 1'b0)
            begin errors++; $display("FAIL abort_done got valid=%0b prod=%h busy=%0b want 0 0 0", o_out_valid, o_product, o_busy); end
    endtask

    task automatic test_reset_mid();
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
        int           lat;
        int           seen;
        start_op(booth_gen({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1));
        for (int i = 0; i < 10; i++) tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_out_valid !== 1'b0 || o_product !== 128'd0 || o_busy !== 1'b0 || o_in_ready !== 1'b1)
            begin errors++; $display("FAIL rstmid_outputs got valid=%0b prod=%h busy=%0b rdy=%0b want 0 0 0 1", o_out_valid, o_product, o_busy, o_in_ready); end
        #4;
        i_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_out_valid || !o_in_ready) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_stale got %0d bad cycles want 0", seen); end
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        exp = ref_mul(a, b, 1'b0, 1'b1);
        start_op(booth_gen(a, b, 1'b0, 1'b1));
        wait_done(lat);
        checks++; if (o_product !== exp || lat != 33) begin errors++; $display("FAIL rstmid_recover got %h lat %0d want %h lat 33", o_product, lat, exp); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
